bram_rmw_accumulator: RTL and testbench
=======================================

# bram_rmw_accumulator

Parametrised BRAM read-modify-write engine for the pulse-model datapath. For each requested pass it reads `NUM_WORDS` words from a single-port BRAM, adds a per-word increment, and writes the results back. It repeats passes until `cps` passes are complete, and restarts whenever `cps` changes. It generalises the fixed 10-word/32-bit dump block with:
- configurable width, depth, address stride and BRAM read latency;
- an optional saturating adder;
- a run-time step input;
- status outputs.

## Interface
Parameters:
- `DATA_W`, 32, BRAM word width
- `ADDR_W`, 32, BRAM address width (byte address)
- `NUM_WORDS`, 10, words processed per pass (1..256)
- `ADDR_STRIDE`, 4, byte stride between consecutive words
- `RD_LAT`, 1, BRAM read latency in cycles (1..4)
- `SATURATE`, 0, 1 = clamp sums at all-ones; 0 = wrap modulo 2^DATA_W

Ports:
- `clk`, in, 1, single clock; all logic is on the rising edge
- `rst`, in, 1, synchronous active-high reset
- `cps`, in, 32, number of passes requested; 0 = stop
- `step`, in, DATA_W, base increment, sampled in CALC
- `bram_en`, out, 1, BRAM enable
- `bram_we`, out, 1, BRAM write enable
- `bram_addr`, out, ADDR_W, BRAM byte address
- `bram_din`, out, DATA_W, BRAM write data
- `bram_dout`, in, DATA_W, BRAM read data, valid `RD_LAT` cycles after the address
- `busy`, out, 1, high in any state other than IDLE
- `pass_done`, out, 1, one-cycle pulse at the end of each pass
- `pass_count`, out, 32, passes completed since the last restart

## Operation
- All outputs are registered. Reset values: `bram_en` = 0, `bram_we` = 0, `bram_addr` = 0, `bram_din` = 0, `busy` = 0, `pass_done` = 0, `pass_count` = 0. The internal latched `cps_q` resets to 0, the state to IDLE, and all buffer entries to 0.
- States: IDLE, READ, CALC, WRITE, DONE.
- Control priority (highest first): `rst`, then `cps == 0`, then `cps != cps_q`, then normal FSM progress.
- **`cps == 0`:** go to IDLE. Clear `bram_en`, `bram_we`, `pass_count` and `cps_q`.
- **`cps != 0` and `cps != cps_q` (restart):**
  - latch `cps_q <= cps`;
  - clear `pass_count`;
  - abort the current pass from any state and enter READ with index 0.
  - Partial writes from an aborted pass are left in the BRAM.
- **IDLE:** outputs inactive. Leave IDLE only by restart.
- **READ:** issue reads on consecutive cycles, one per word.
  - Issue cycle i (i = 0..NUM_WORDS-1): `bram_en` = 1, `bram_we` = 0, `bram_addr` = i*ADDR_STRIDE.
  - Capture `bram_dout` into `buf[i]` exactly RD_LAT cycles after issue. Use an RD_LAT-deep valid/index shift pipe.
  - Hold `bram_en` = 0 after the last issue.
  - Go to CALC when the last capture lands.
- **CALC (1 cycle):** `buf[i] <= f(buf[i] + (i+1)*step)`.
  - The product and sum are computed at DATA_W+8 bits.
  - `f` is truncation to DATA_W bits when `SATURATE` = 0, or a clamp to 2^DATA_W−1 when `SATURATE` = 1.
- **WRITE:** one write per cycle, `NUM_WORDS` cycles.
  - `bram_en` = 1, `bram_we` = 1, `bram_addr` = i*ADDR_STRIDE, `bram_din` = `buf[i]`.
  - Exactly `NUM_WORDS` writes; no write to index `NUM_WORDS`.
- **DONE (1 cycle):**
  - `bram_en` = 0, `bram_we` = 0, `pass_done` = 1, `pass_count <= pass_count + 1`.
  - Go to READ if `pass_count + 1 < cps_q`, otherwise to IDLE.
- **Completion and saturation:** after `cps_q` passes, stay in IDLE until `cps` changes. `pass_count` saturates at 2^32−1.

## Timing
- Pass length is 2*NUM_WORDS + RD_LAT + 2 cycles: READ = NUM_WORDS + RD_LAT, CALC = 1, WRITE = NUM_WORDS, DONE = 1. With defaults this is 23 cycles.
- The first read address appears on the edge after the cycle in which the `cps` change is sampled.
- Back-to-back passes have no idle gap: DONE is followed directly by the first READ issue.
- `busy` rises with the first READ issue and falls on the edge after DONE of the final pass.
- A restart seen during WRITE deasserts `bram_we` on the next edge. The write issued in that same cycle still completes.
- `rst` asserted in any state drives all outputs to their reset values on the next edge.
- `step` may change at any time; only the value present in the CALC cycle is used.

## Test plan
- BRAM preloaded with zeros, `step` = 1, `cps` 0→1: after 23 cycles words 0..9 = 1,2,…,10; `pass_count` = 1; exactly one `pass_done` pulse; `busy` low afterwards.
- `cps` = 3, `step` = 2, zeros preloaded: word i = 6(i+1), i.e. word 9 = 60; `pass_count` = 3; `busy` high for 69 cycles.
- Word 0 preloaded with 0xFFFFFFFE, `step` = 5, `cps` = 1: with `SATURATE` = 1 word 0 = 0xFFFFFFFF; with `SATURATE` = 0 word 0 = 0x00000003.
- `cps` changes 2→4 during WRITE of pass 1: `bram_we` low the next edge; `pass_count` = 0; READ restarts at address 0; 4 full passes follow.
- `rst` pulsed mid-READ, then `cps` 0→1: outputs zero on the edge after `rst`; after the new start, one clean pass yields the same values as scenario 1.
- `RD_LAT` = 3, `NUM_WORDS` = 16, `ADDR_STRIDE` = 8, `cps` = 1, `step` = 1: pass takes 37 cycles; word at address 15*8 = 16; no access at address 128.

Source files
------------

// File: rtl/bram_rmw_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_rmw_accumulator_if
// Description : Single-port BRAM bus between the RMW accumulator and its BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_rmw_accumulator_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    modport master (
        output bram_en,
        output bram_we,
        output bram_addr,
        output bram_din,
        input  bram_dout
    );

    modport slave (
        input  bram_en,
        input  bram_we,
        input  bram_addr,
        input  bram_din,
        output bram_dout
    );
endinterface
`default_nettype wire

// File: rtl/bram_rmw_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : bram_rmw_accumulator
// Description : Repeated read / add (i+1)*step / write-back passes over a BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_rmw_accumulator #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_WORDS   = 10,
    parameter int ADDR_STRIDE = 4,
    parameter int RD_LAT      = 1,
    parameter int SATURATE    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            cps,
    input  logic [DATA_W-1:0]      step,
    bram_rmw_accumulator_if.master bus,
    output logic                   busy,
    output logic                   pass_done,
    output logic [31:0]            pass_count
);
    localparam int c_IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int c_SUM_W = DATA_W + 8;
    localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0]  c_STRIDE = ADDR_W'(ADDR_STRIDE);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_READ  = 3'd1;
    localparam logic [2:0] c_ST_CALC  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [31:0]        r_cps_q;
    logic [c_IDX_W-1:0] r_idx;
    logic [DATA_W-1:0]  r_buf [NUM_WORDS];
    logic [RD_LAT-1:0]  r_pv;
    logic [c_IDX_W-1:0] r_pidx [RD_LAT];
    logic               r_en, r_we, r_busy, r_done;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_din;
    logic [31:0]        r_count;

    logic [2:0]         w_state_nxt;
    logic               w_stop, w_restart, w_hold, w_cap;
    logic [c_IDX_W-1:0] w_cap_idx, w_idx_inc, w_idx_nxt;
    logic               w_en_nxt, w_we_nxt, w_busy_nxt, w_done_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [DATA_W-1:0]  w_din_nxt;
    logic [31:0]        w_count_nxt;
    logic [DATA_W-1:0]  w_calc [NUM_WORDS];

    assign w_stop    = (cps == 32'd0);
    assign w_restart = !w_stop && (cps != r_cps_q);
    assign w_hold    = !w_stop && !w_restart;
    assign w_cap     = r_pv[RD_LAT-1];
    assign w_cap_idx = r_pidx[RD_LAT-1];
    assign w_idx_inc = r_idx + c_IDX_W'(1);

    // Per-word update value; the widened sum lets SATURATE detect carry-out.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_calc
        logic [c_SUM_W-1:0] w_sum;
        assign w_sum = c_SUM_W'(r_buf[gi]) + c_SUM_W'(gi + 1) * c_SUM_W'(step);
        if (SATURATE != 0) begin : g_sat
            assign w_calc[gi] = (|w_sum[c_SUM_W-1:DATA_W]) ? '1 : w_sum[DATA_W-1:0];
        end else begin : g_wrap
            assign w_calc[gi] = w_sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cps_q <= '0;
            r_idx   <= '0;
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_pv    <= '0;
            for (int k = 0; k < RD_LAT; k++) r_pidx[k] <= '0;
            for (int i = 0; i < NUM_WORDS; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_en    <= w_en_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_din   <= w_din_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
            if (w_stop) begin
                r_cps_q <= '0;
            end else if (w_restart) begin
                r_cps_q <= cps;
            end
            // Reads are tracked from the cycle they are on the bus; an abort flushes them.
            r_pv[0]   <= w_hold && (r_state == c_ST_READ) && r_en;
            r_pidx[0] <= r_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k]   <= w_hold && r_pv[k-1];
                r_pidx[k] <= r_pidx[k-1];
            end
            if (w_hold && (r_state == c_ST_READ) && w_cap) begin
                r_buf[w_cap_idx] <= bus.bram_dout;
            end
            if (w_hold && (r_state == c_ST_CALC)) begin
                for (int i = 0; i < NUM_WORDS; i++) r_buf[i] <= w_calc[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_restart) begin
            w_state_nxt = c_ST_READ;
        end else begin
            case (r_state)
                c_ST_IDLE:  w_state_nxt = c_ST_IDLE;
                c_ST_READ:  if (w_cap && (w_cap_idx == c_LAST)) w_state_nxt = c_ST_CALC;
                c_ST_CALC:  w_state_nxt = c_ST_WRITE;
                c_ST_WRITE: if (r_idx == c_LAST) w_state_nxt = c_ST_DONE;
                c_ST_DONE:  w_state_nxt = (r_count < r_cps_q) ? c_ST_READ : c_ST_IDLE;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_en_nxt    = r_en;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_count_nxt = r_count;
        if (w_stop) begin
            w_en_nxt    = 1'b0;
            w_we_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_count_nxt = '0;
        end else if (w_restart || ((r_state == c_ST_DONE) && (w_state_nxt == c_ST_READ))) begin
            w_en_nxt   = 1'b1;
            w_we_nxt   = 1'b0;
            w_addr_nxt = '0;
            w_idx_nxt  = '0;
            w_busy_nxt = 1'b1;
            if (w_restart) w_count_nxt = '0;
        end else begin
            case (r_state)
                c_ST_READ: begin
                    if (r_en) begin
                        if (r_idx != c_LAST) begin
                            w_idx_nxt  = w_idx_inc;
                            w_addr_nxt = r_addr + c_STRIDE;
                        end else begin
                            w_en_nxt = 1'b0;
                        end
                    end
                end
                c_ST_CALC: begin
                    // Word 0 is written straight from the adder as buf updates on this edge.
                    w_en_nxt   = 1'b1;
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = '0;
                    w_idx_nxt  = '0;
                    w_din_nxt  = w_calc[0];
                end
                c_ST_WRITE: begin
                    if (r_idx != c_LAST) begin
                        w_idx_nxt  = w_idx_inc;
                        w_addr_nxt = r_addr + c_STRIDE;
                        w_din_nxt  = r_buf[w_idx_inc];
                    end else begin
                        w_en_nxt    = 1'b0;
                        w_we_nxt    = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_count_nxt = (&r_count) ? r_count : r_count + 32'd1;
                    end
                end
                c_ST_DONE: begin
                    w_en_nxt   = 1'b0;
                    w_we_nxt   = 1'b0;
                    w_busy_nxt = 1'b0;
                end
                default: begin
                    w_en_nxt   = 1'b0;
                    w_we_nxt   = 1'b0;
                    w_busy_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.bram_en   = r_en;
    assign bus.bram_we   = r_we;
    assign bus.bram_addr = r_addr;
    assign bus.bram_din  = r_din;
    assign busy          = r_busy;
    assign pass_done     = r_done;
    assign pass_count    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_bram_rmw_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_rmw_accumulator
// Description : Two accumulator instances (wrap/lat1/10 words, sat/lat3/16 words)
//               against BRAM models and a per-pass arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_rmw_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cps_v  [2];
    logic [31:0] step_v [2];
    logic        load_v [2];
    logic [31:0] init_v [2][16];
    logic [31:0] mdl    [2][16];

    logic        busy_a, busy_b, done_a, done_b;
    logic [31:0] cnt_a, cnt_b;
    logic        en_s [2], we_s [2], busy_s [2], done_s [2];
    logic [31:0] addr_s [2], din_s [2], cnt_s [2];

    int n_cmp = 0;
    int n_err = 0;
    int pulses [2] = '{0, 0};
    int writes [2] = '{0, 0};
    int bad    [2] = '{0, 0};

    always #5 clk = ~clk;

    bram_rmw_accumulator_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    bram_rmw_accumulator_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

    bram_rmw_accumulator #(
        .DATA_W(32), .ADDR_W(32), .NUM_WORDS(10), .ADDR_STRIDE(4), .RD_LAT(1), .SATURATE(0)
    ) dut_a (
        .clk(clk), .rst(rst), .cps(cps_v[0]), .step(step_v[0]), .bus(bus_a),
        .busy(busy_a), .pass_done(done_a), .pass_count(cnt_a)
    );

    bram_rmw_accumulator #(
        .DATA_W(32), .ADDR_W(32), .NUM_WORDS(16), .ADDR_STRIDE(8), .RD_LAT(3), .SATURATE(1)
    ) dut_b (
        .clk(clk), .rst(rst), .cps(cps_v[1]), .step(step_v[1]), .bus(bus_b),
        .busy(busy_b), .pass_done(done_b), .pass_count(cnt_b)
    );

    assign en_s[0]   = bus_a.bram_en;    assign en_s[1]   = bus_b.bram_en;
    assign we_s[0]   = bus_a.bram_we;    assign we_s[1]   = bus_b.bram_we;
    assign addr_s[0] = bus_a.bram_addr;  assign addr_s[1] = bus_b.bram_addr;
    assign din_s[0]  = bus_a.bram_din;   assign din_s[1]  = bus_b.bram_din;
    assign busy_s[0] = busy_a;           assign busy_s[1] = busy_b;
    assign done_s[0] = done_a;           assign done_s[1] = done_b;
    assign cnt_s[0]  = cnt_a;            assign cnt_s[1]  = cnt_b;

    function automatic int nw(input int d);     return (d == 0) ? 10 : 16; endfunction
    function automatic int stride(input int d); return (d == 0) ? 4 : 8;   endfunction
    function automatic int plen(input int d);   return (d == 0) ? 23 : 37; endfunction
    function automatic bit sat(input int d);    return d != 0;             endfunction

    function automatic bit in_range(input int d, input logic [31:0] a);
        logic [31:0] st;
        st = 32'(stride(d));
        return ((a % st) == 32'd0) && ((a / st) < 32'(nw(d)));
    endfunction

    // BRAM models: latency 1 for instance a, 3 for instance b.
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] rd_a, rd_b0, rd_b1, rd_b2;

    always @(posedge clk) begin
        if (load_v[0]) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= init_v[0][i];
        end else if (bus_a.bram_en && in_range(0, bus_a.bram_addr)) begin
            if (bus_a.bram_we) mem_a[bus_a.bram_addr[5:2]] <= bus_a.bram_din;
            rd_a <= mem_a[bus_a.bram_addr[5:2]];
        end
    end
    assign bus_a.bram_dout = rd_a;

    always @(posedge clk) begin
        rd_b1 <= rd_b0;
        rd_b2 <= rd_b1;
        if (load_v[1]) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= init_v[1][i];
        end else if (bus_b.bram_en && in_range(1, bus_b.bram_addr)) begin
            if (bus_b.bram_we) mem_b[bus_b.bram_addr[6:3]] <= bus_b.bram_din;
            rd_b0 <= mem_b[bus_b.bram_addr[6:3]];
        end
    end
    assign bus_b.bram_dout = rd_b2;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst) begin
                if (done_s[m]) pulses[m] <= pulses[m] + 1;
                if (en_s[m] && we_s[m]) writes[m] <= writes[m] + 1;
                if (en_s[m] && !in_range(m, addr_s[m])) bad[m] <= bad[m] + 1;
            end
        end
    end

    function automatic logic [31:0] rd_mem(input int d, input int i);
        logic [3:0] ix;
        ix = 4'(i);
        return (d == 0) ? mem_a[ix] : mem_b[ix];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pass of the reference: word i gains (i+1)*step, then wraps or clamps.
    task automatic model_pass(input int d, input logic [31:0] s, input int upto);
        for (int i = 0; i < upto; i++) begin
            logic [63:0] sum;
            sum = (64'(mdl[d][i]) + 64'(i + 1) * 64'(s)) & 64'hFF_FFFF_FFFF;
            if (sat(d) && (sum > 64'hFFFF_FFFF)) mdl[d][i] = 32'hFFFF_FFFF;
            else mdl[d][i] = sum[31:0];
        end
    endtask

    task automatic preload(input int d, input bit rnd, input bit w0_en, input logic [31:0] w0);
        for (int i = 0; i < 16; i++) begin
            init_v[d][i] = rnd ? 32'($urandom) : 32'd0;
            if (i == 0 && w0_en) init_v[d][i] = w0;
            mdl[d][i] = init_v[d][i];
        end
        load_v[d] = 1'b1;
        @(negedge clk);
        load_v[d] = 1'b0;
    endtask

    task automatic chk_idle_zero(input int d, input string pfx);
        chk($sformatf("%s_en%0d", pfx, d),   en_s[d],   0);
        chk($sformatf("%s_we%0d", pfx, d),   we_s[d],   0);
        chk($sformatf("%s_addr%0d", pfx, d), addr_s[d], 0);
        chk($sformatf("%s_din%0d", pfx, d),  din_s[d],  0);
        chk($sformatf("%s_busy%0d", pfx, d), busy_s[d], 0);
        chk($sformatf("%s_done%0d", pfx, d), done_s[d], 0);
        chk($sformatf("%s_cnt%0d", pfx, d),  cnt_s[d],  0);
    endtask

    task automatic compare_mem(input int d, input string pfx);
        for (int i = 0; i < nw(d); i++)
            chk($sformatf("%s_mem%0d_w%0d", pfx, d, i), rd_mem(d, i), mdl[d][i]);
    endtask

    task automatic run(input int d, input int c, input logic [31:0] s, input string pfx);
        int pd0, wr0, bd0, cyc;
        pd0 = pulses[d]; wr0 = writes[d]; bd0 = bad[d];
        step_v[d] = s;
        cps_v[d]  = 32'(c);
        @(negedge clk);
        chk({pfx, "_first_en"}, en_s[d] & ~we_s[d], 1);
        chk({pfx, "_first_addr"}, addr_s[d], 0);
        cyc = 0;
        while (busy_s[d] && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        chk({pfx, "_busy_cycles"}, 64'(cyc), 64'(c * plen(d)));
        chk({pfx, "_pass_count"}, cnt_s[d], 64'(c));
        chk({pfx, "_pulses"}, 64'(pulses[d] - pd0), 64'(c));
        chk({pfx, "_writes"}, 64'(writes[d] - wr0), 64'(c * nw(d)));
        chk({pfx, "_bad_addr"}, 64'(bad[d] - bd0), 0);
        for (int p = 0; p < c; p++) model_pass(d, s, nw(d));
        compare_mem(d, pfx);
    endtask

    task automatic stop(input int d);
        cps_v[d] = 32'd0;
        @(negedge clk);
        chk("stop_cnt", cnt_s[d], 0);
        chk("stop_busy", busy_s[d], 0);
    endtask

    initial begin
        int          cyc, j, wr0, pd0, d_r;
        logic [31:0] s;
        for (int d = 0; d < 2; d++) begin
            cps_v[d] = 32'd0; step_v[d] = 32'd0; load_v[d] = 1'b0;
        end
        preload(0, 1'b0, 1'b0, 32'd0);
        preload(1, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        chk_idle_zero(0, "reset");
        chk_idle_zero(1, "reset");
        rst = 1'b0;
        @(negedge clk);

        // Single pass from zeros, then three passes with step 2.
        run(0, 1, 32'd1, "one");
        chk("one_w9", rd_mem(0, 9), 10);
        stop(0);
        preload(0, 1'b0, 1'b0, 32'd0);
        run(0, 3, 32'd2, "three");
        chk("three_w9", rd_mem(0, 9), 60);
        stop(0);

        // Overflow of word 0: wraps on a, clamps on b.
        preload(0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        run(0, 1, 32'd5, "wrap");
        chk("wrap_w0", rd_mem(0, 0), 32'h0000_0003);
        stop(0);
        preload(1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        run(1, 1, 32'd5, "sat");
        chk("sat_w0", rd_mem(1, 0), 32'hFFFF_FFFF);
        stop(1);
        preload(1, 1'b0, 1'b0, 32'd0);
        run(1, 1, 32'd1, "lat3");
        chk("lat3_w15", rd_mem(1, 15), 16);
        stop(1);

        // cps 2 -> 4 during the write phase of the first pass.
        preload(0, 1'b1, 1'b0, 32'd0);
        s = 32'($urandom);
        step_v[0] = s;
        cps_v[0]  = 32'd2;
        @(negedge clk);
        cyc = 0;
        while (!we_s[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rs_we_seen", we_s[0], 1);
        j = int'($urandom_range(0, 9));
        repeat (j) @(negedge clk);
        cps_v[0] = 32'd4;
        model_pass(0, s, j + 1);
        wr0 = writes[0]; pd0 = pulses[0];
        @(negedge clk);
        chk("rs_we_drop", we_s[0], 0);
        chk("rs_cnt_clear", cnt_s[0], 0);
        chk("rs_en", en_s[0], 1);
        chk("rs_addr", addr_s[0], 0);
        cyc = 0;
        while (busy_s[0] && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        chk("rs_busy_cycles", 64'(cyc), 64'(4 * 23));
        chk("rs_pass_count", cnt_s[0], 4);
        chk("rs_pulses", 64'(pulses[0] - pd0), 4);
        chk("rs_writes", 64'(writes[0] - wr0), 41);
        for (int p = 0; p < 4; p++) model_pass(0, s, 10);
        compare_mem(0, "rs");
        stop(0);

        // Reset in the middle of the read phase, then a clean pass.
        preload(0, 1'b0, 1'b0, 32'd0);
        step_v[0] = 32'd1;
        cps_v[0]  = 32'd1;
        repeat (int'($urandom_range(2, 6))) @(negedge clk);
        chk("rr_in_read", en_s[0] & ~we_s[0], 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_zero(0, "rr");
        cps_v[0] = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(0, 1, 32'd1, "rr_run");
        chk("rr_w4", rd_mem(0, 4), 5);
        stop(0);

        // Random contents, step and pass counts on both instances.
        for (int k = 0; k < 6; k++) begin
            d_r = k % 2;
            preload(d_r, 1'b1, 1'b0, 32'd0);
            s = (k >= 4) ? 32'($urandom) : 32'($urandom_range(0, 100000));
            run(d_r, int'($urandom_range(1, 3)), s, $sformatf("rnd%0d", k));
            stop(d_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
